id_scoreboard: RTL

- Parametrised register scoreboard beside the ID stage; generalises single-cycle load-use detection to variable-latency producers (load, mul, div).
- Keeps one countdown per architectural register. Raises a stall for RAW hazards whose result is not yet forwardable, and for WAW hazards that would write back out of order.
- Existing EXE/MEM forwarding muxes still supply the data once the count reaches 0.

---
 rtl/id_scoreboard_pkg.sv | 15 +
 rtl/id_scoreboard_sb_entry.sv | 45 ++++
 rtl/id_scoreboard.sv | 123 ++++++++++++
 3 files changed

// File: rtl/id_scoreboard_pkg.sv
// Shared constants for the ID-stage register scoreboard.
// Producer latencies are counted in cycles after issue until the result is
// forwardable.
package id_scoreboard_pkg;

    localparam int RADDR_WIDTH = 5;

    localparam int LAT_ALU  = 0;
    localparam int LAT_LOAD = 1;
    localparam int LAT_MUL  = 3;
    localparam int LAT_DIV  = 7;

    localparam logic [31:0] STALL_CNT_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/id_scoreboard_sb_entry.sv
// sb_entry: one per-register countdown of cycles until the register's pending
// result becomes forwardable. A load takes priority over the decrement, the
// whole entry freezes when en_i is low, and rst_n_i clears it asynchronously.
module sb_entry
    import id_scoreboard_pkg::*;
#(
    parameter int LAT_W = 3
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [LAT_W-1:0] lat_i,
    output logic [LAT_W-1:0] cnt_o,
    output logic             busy_o
);

    logic [LAT_W-1:0] cnt_d;
    logic [LAT_W-1:0] cnt_q;

    // Next count: a new producer's latency wins, otherwise count down to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            if (load_i) begin
                cnt_d = lat_i;
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - LAT_W'(1);
            end
        end
    end

    // Countdown register with asynchronous clear.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/id_scoreboard.sv
// id_scoreboard: register scoreboard beside the ID stage. Tracks, per
// architectural register, how many cycles remain until a variable-latency
// producer's result is forwardable, and requests a stall for RAW hazards on
// not-yet-forwardable sources and for WAW hazards that would retire out of
// order. x0 is never tracked; addresses >= NREG read as not busy.
// Optional build macro: ID_SCOREBOARD_STATS_EN adds a saturating 32-bit
// stall-cycle counter on stall_cycles_o (tied to 0 otherwise).
module id_scoreboard
    import id_scoreboard_pkg::*;
#(
    parameter int NREG    = 32,
    parameter int RADDR_W = RADDR_WIDTH,
    parameter int LAT_W   = 3
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               id_valid_i,
    input  logic               flush_i,
    input  logic               hold_i,
    input  logic [RADDR_W-1:0] rs1_addr_i,
    input  logic               rs1_re_i,
    input  logic [RADDR_W-1:0] rs2_addr_i,
    input  logic               rs2_re_i,
    input  logic [RADDR_W-1:0] rd_addr_i,
    input  logic               rd_we_i,
    input  logic [LAT_W-1:0]   rd_lat_i,
    output logic               stallreq_o,
    output logic               raw_hazard_o,
    output logic               waw_hazard_o,
    output logic [NREG-1:0]    busy_vec_o,
    output logic [31:0]        stall_cycles_o
);

    logic [LAT_W-1:0] cnt [1:NREG-1];
    logic [NREG-1:0]  busy_vec;
    logic [LAT_W-1:0] rs1_cnt;
    logic [LAT_W-1:0] rs2_cnt;
    logic [LAT_W-1:0] rd_cnt;
    logic             raw_hazard;
    logic             waw_hazard;
    logic             stallreq;
    logic             issue;

    assign busy_vec[0] = 1'b0;

    // One countdown per tracked register; only a genuinely issued
    // multi-cycle producer reloads its destination entry.
    genvar gi;
    generate
        for (gi = 1; gi < NREG; gi++) begin : g_entry
            logic load;
            assign load = issue & rd_we_i & (rd_addr_i == RADDR_W'(gi))
                        & (rd_lat_i != '0);

            sb_entry #(
                .LAT_W (LAT_W)
            ) u_entry (
                .clk_i   (clk_i),
                .rst_n_i (rst_n_i),
                .en_i    (~hold_i),
                .load_i  (load),
                .lat_i   (rd_lat_i),
                .cnt_o   (cnt[gi]),
                .busy_o  (busy_vec[gi])
            );
        end
    endgenerate

    // Read the current counts of rs1/rs2/rd; x0 and out-of-range addresses
    // match no entry and therefore read as zero.
    always_comb begin
        rs1_cnt = '0;
        rs2_cnt = '0;
        rd_cnt  = '0;
        for (int r = 1; r < NREG; r++) begin
            if (rs1_addr_i == RADDR_W'(r)) rs1_cnt = cnt[r];
            if (rs2_addr_i == RADDR_W'(r)) rs2_cnt = cnt[r];
            if (rd_addr_i  == RADDR_W'(r)) rd_cnt  = cnt[r];
        end
    end

    // Hazard detection against pre-update counts. An equal count is not a
    // WAW hazard because both writers then retire in program order.
    always_comb begin
        raw_hazard = (rs1_re_i & (rs1_cnt != '0))
                   | (rs2_re_i & (rs2_cnt != '0));
        waw_hazard = rd_we_i & (rd_addr_i != '0) & (rd_cnt > rd_lat_i);
        stallreq   = id_valid_i & ~flush_i & (raw_hazard | waw_hazard);
        issue      = id_valid_i & ~flush_i & ~hold_i & ~stallreq;
    end

    assign raw_hazard_o = raw_hazard;
    assign waw_hazard_o = waw_hazard;
    assign stallreq_o   = stallreq;
    assign busy_vec_o   = busy_vec;

`ifdef ID_SCOREBOARD_STATS_EN
    logic [31:0] stall_cnt_d;
    logic [31:0] stall_cnt_q;

    // Count edges on which the pipeline really spends a cycle stalled.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stallreq && !hold_i && (stall_cnt_q != STALL_CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Stall statistics register with asynchronous clear.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cycles_o = stall_cnt_q;
`else
    assign stall_cycles_o = '0;
`endif

endmodule
